piece_drawer: RTL and testbench

PIECE_DRAWER -- requirements
Module: piece_drawer

---
 rtl/piece_drawer.sv | 188 ++++++++++++++++++
 tb/tb_piece_drawer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_drawer.sv
// piece_drawer: renders one four-cell board piece as 4x4 pixel squares
// through a single-pixel-per-cycle VGA write port. Inputs are snapshotted
// when a draw starts; cells that fall off the 10x20 board are walked but
// not plotted, so a draw always takes exactly 64 pixel cycles.
module piece_drawer #(
    parameter logic [7:0] BOARD_X0 = 8'd60,
    parameter logic [6:0] BOARD_Y0 = 7'd20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       erase,
    input  logic [3:0] origin_x,
    input  logic [4:0] origin_y,
    input  logic [7:0] cells_x,
    input  logic [7:0] cells_y,
    input  logic [5:0] colour,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [5:0] vga_colour
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   accept_s;

    // Snapshot of the piece being drawn
    logic [3:0] ox_r;
    logic [4:0] oy_r;
    logic [7:0] cx_r;
    logic [7:0] cy_r;
    logic [5:0] colour_r;
    logic       erase_r;
    logic [5:0] cnt_r;

    // Pixel datapath: source is the live inputs on the accepting edge,
    // the snapshot afterwards
    logic [3:0] src_ox_s;
    logic [4:0] src_oy_s;
    logic [7:0] src_cx_s;
    logic [7:0] src_cy_s;
    logic [5:0] src_colour_s;
    logic       src_erase_s;
    logic [5:0] idx_s;
    logic [1:0] cell_cx_s;
    logic [1:0] cell_cy_s;
    logic [4:0] col_s;
    logic [4:0] row_s;
    logic [7:0] pix_x_s;
    logic [6:0] pix_y_s;
    logic [5:0] pix_colour_s;
    logic       clip_s;

    // Picks the 2-bit offset of cell i out of a packed offset byte
    function automatic logic [1:0] sel2(input logic [7:0] v, input logic [1:0] i);
        logic [1:0] r;
        case (i)
            2'd0:    r = v[1:0];
            2'd1:    r = v[3:2];
            2'd2:    r = v[5:4];
            default: r = v[7:6];
        endcase
        return r;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start only matters in IDLE
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = DRAW;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRAW: begin
                if (cnt_r == 6'd63) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAW;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next pixel position, colour and clipping decision
    always_comb begin
        if (accept_s) begin
            src_ox_s     = origin_x;
            src_oy_s     = origin_y;
            src_cx_s     = cells_x;
            src_cy_s     = cells_y;
            src_colour_s = colour;
            src_erase_s  = erase;
            idx_s        = 6'd0;
        end else begin
            src_ox_s     = ox_r;
            src_oy_s     = oy_r;
            src_cx_s     = cx_r;
            src_cy_s     = cy_r;
            src_colour_s = colour_r;
            src_erase_s  = erase_r;
            idx_s        = cnt_r + 6'd1;
        end
        cell_cx_s    = sel2(src_cx_s, idx_s[5:4]);
        cell_cy_s    = sel2(src_cy_s, idx_s[5:4]);
        col_s        = {1'b0, src_ox_s} + {3'b000, cell_cx_s};
        row_s        = src_oy_s + {3'b000, cell_cy_s};
        pix_x_s      = BOARD_X0 + {1'b0, col_s, 2'b00} + {6'b000000, idx_s[1:0]};
        pix_y_s      = BOARD_Y0 + {row_s, 2'b00} + {5'b00000, idx_s[3:2]};
        clip_s       = (col_s > 5'd9) || (row_s > 5'd19);
        pix_colour_s = src_erase_s ? 6'b000000 : src_colour_s;
    end

    // Input snapshot and pixel counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ox_r     <= 4'd0;
            oy_r     <= 5'd0;
            cx_r     <= 8'd0;
            cy_r     <= 8'd0;
            colour_r <= 6'd0;
            erase_r  <= 1'b0;
            cnt_r    <= 6'd0;
        end else if (accept_s) begin
            ox_r     <= origin_x;
            oy_r     <= origin_y;
            cx_r     <= cells_x;
            cy_r     <= cells_y;
            colour_r <= colour;
            erase_r  <= erase;
            cnt_r    <= 6'd0;
        end else if (state_r == DRAW) begin
            cnt_r    <= (state_s == DRAW) ? (cnt_r + 6'd1) : 6'd0;
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Registered outputs; pixel registers only load while drawing
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 6'd0;
        end else begin
            busy <= (state_s == DRAW);
            done <= (state_r == DRAW) && (state_s == DONE);
            plot <= (state_s == DRAW) && !clip_s;
            if (state_s == DRAW) begin
                vga_x      <= pix_x_s;
                vga_y      <= pix_y_s;
                vga_colour <= pix_colour_s;
            end else begin
                vga_x      <= vga_x;
                vga_y      <= vga_y;
                vga_colour <= vga_colour;
            end
        end
    end

endmodule

// File: tb/tb_piece_drawer.sv
// Scoreboard bench for piece_drawer: stimulus pushes expected pixels and
// done cycles, a negedge monitor pops and compares whatever the DUT emits.
module tb_piece_drawer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       erase = 1'b0;
    logic [3:0] origin_x = 4'd0;
    logic [4:0] origin_y = 5'd0;
    logic [7:0] cells_x = 8'd0;
    logic [7:0] cells_y = 8'd0;
    logic [5:0] colour = 6'd0;
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [5:0] vga_colour;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } pix_t;

    pix_t pixq[$];
    pix_t plog[$];
    int   doneq[$];
    int   dlog[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    piece_drawer dut (
        .clk(clk), .resetn(resetn), .start(start), .erase(erase),
        .origin_x(origin_x), .origin_y(origin_y),
        .cells_x(cells_x), .cells_y(cells_y), .colour(colour),
        .busy(busy), .done(done), .plot(plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: expected pixels of one piece accepted on edge a
    task automatic push_piece(input int a, input int ox, input int oy, input int cx,
                              input int cy, input int col, input int er);
        for (int c = 0; c < 4; c++) begin
            for (int py = 0; py < 4; py++) begin
                for (int px = 0; px < 4; px++) begin
                    pix_t p;
                    int cc;
                    int rr;
                    cc = ox + ((cx >> (2 * c)) & 3);
                    rr = oy + ((cy >> (2 * c)) & 3);
                    if (cc <= 9 && rr <= 19) begin
                        p.cyc = a + c * 16 + py * 4 + px;
                        p.x   = 60 + 4 * cc + px;
                        p.y   = 20 + 4 * rr + py;
                        p.c   = (er != 0) ? 0 : col;
                        pixq.push_back(p);
                    end
                end
            end
        end
        doneq.push_back(a + 64);
    endtask

    // Monitor: compare every plotted pixel and done pulse against the queues
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            pix_t g;
            pix_t e;
            g.cyc = cyc; g.x = int'(vga_x); g.y = int'(vga_y); g.c = int'(vga_colour);
            plog.push_back(g);
            if (pixq.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_plot: got x=%0d y=%0d at cycle %0d required none", g.x, g.y, cyc);
            end else begin
                e = pixq.pop_front();
                chk("pix_cycle", g.cyc, e.cyc);
                chk("pix_x", g.x, e.x);
                chk("pix_y", g.y, e.y);
                chk("pix_colour", g.c, e.c);
            end
        end
        if (done === 1'b1) begin
            dlog.push_back(cyc);
            if (doneq.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
            end else begin
                chk("done_cycle", cyc, doneq.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic draw(input int ox, input int oy, input int cx, input int cy,
                        input int col, input int er, output int a);
        @(negedge clk);
        origin_x = 4'(ox); origin_y = 5'(oy); cells_x = 8'(cx); cells_y = 8'(cy);
        colour = 6'(col); erase = (er != 0);
        start = 1'b1;
        a = cyc + 1;
        push_piece(a, ox, oy, cx, cy, col, er);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_vga_x"}, int'(vga_x), 0);
        chk({tag, "_vga_y"}, int'(vga_y), 0);
        chk({tag, "_vga_colour"}, int'(vga_colour), 0);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_pix_left"}, pixq.size(), 0);
        chk({tag, "_done_left"}, doneq.size(), 0);
    endtask

    initial begin
        int a;
        int a2;
        int n0;
        int d0;
        int nz;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic piece: cell offsets x = 3,2,1,0, origin (3,0)
        n0 = plog.size();
        draw(3, 0, 8'b00_01_10_11, 0, 6'b001111, 0, a);
        chk("t1_busy", int'(busy), 1);
        wait_cyc(a + 66);
        chk("t1_nplots", plog.size() - n0, 64);
        chk("t1_first_x", plog[n0].x, 84);
        chk("t1_first_y", plog[n0].y, 20);
        chk("t1_first_cyc", plog[n0].cyc, a);
        chk("t1_last_x", plog[n0 + 63].x, 75);
        chk("t1_last_y", plog[n0 + 63].y, 23);
        chk("t1_last_cyc", plog[n0 + 63].cyc, a + 63);
        chk("t1_done_cyc", dlog[dlog.size() - 1], a + 64);
        chk("t1_busy_after", int'(busy), 0);
        drained("t1");

        // Right-edge clipping: cells 0 and 1 fall off the board
        n0 = plog.size();
        draw(8, 0, 8'b00_01_10_11, 0, 6'b001111, 0, a);
        wait_cyc(a + 66);
        chk("t2_nplots", plog.size() - n0, 32);
        chk("t2_first_x", plog[n0].x, 96);
        chk("t2_first_cyc", plog[n0].cyc, a + 32);
        chk("t2_last_x", plog[n0 + 31].x, 95);
        chk("t2_last_y", plog[n0 + 31].y, 23);
        chk("t2_done_cyc", dlog[dlog.size() - 1], a + 64);
        drained("t2");

        // Erase forces black regardless of colour
        n0 = plog.size();
        draw(1, 4, 8'b00_01_10_11, 8'b01_01_00_00, 6'b110000, 1, a);
        wait_cyc(a + 66);
        nz = 0;
        for (int i = n0; i < plog.size(); i++) if (plog[i].c != 0) nz++;
        chk("t3_nplots", plog.size() - n0, 64);
        chk("t3_nonblack", nz, 0);
        drained("t3");

        // Start during DRAW and DONE ignored; accepted again at a+66
        d0 = dlog.size();
        draw(0, 0, 8'b11_10_01_00, 0, 6'b010101, 0, a);
        wait_cyc(a + 9);
        origin_x = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(a + 64);
        origin_x = 4'd2; origin_y = 5'd10; cells_x = 8'b00_00_01_01;
        cells_y = 8'b01_00_01_00; colour = 6'b101010; erase = 1'b0;
        start = 1'b1;
        a2 = a + 66;
        push_piece(a2, 2, 10, 8'b00_00_01_01, 8'b01_00_01_00, 6'b101010, 0);
        wait_cyc(a + 66);
        chk("t4_one_done", dlog.size() - d0, 1);
        start = 1'b0;
        chk("t4_busy_restart", int'(busy), 1);
        wait_cyc(a2 + 66);
        chk("t4_two_dones", dlog.size() - d0, 2);
        drained("t4");

        // Reset mid-draw aborts with no done; reset beats start
        d0 = dlog.size();
        draw(4, 6, 8'b00_01_10_11, 8'b11_10_01_00, 6'b000011, 0, a);
        wait_cyc(a + 29);
        resetn = 1'b0; start = 1'b1;
        @(negedge clk);
        check_idle_zero("t5_abort");
        pixq.delete();
        doneq.delete();
        @(negedge clk);
        chk("t5_reset_vs_start_busy", int'(busy), 0);
        resetn = 1'b1; start = 1'b0;
        repeat (70) @(negedge clk);
        chk("t5_no_done", dlog.size() - d0, 0);
        n0 = plog.size();
        draw(3, 0, 8'b00_01_10_11, 0, 6'b001111, 0, a);
        wait_cyc(a + 66);
        chk("t5_redraw_nplots", plog.size() - n0, 64);
        drained("t5");

        // Snapshot: inputs changed mid-draw do not affect the piece
        draw(2, 0, 8'b00_01_00_01, 8'b01_01_00_00, 6'b010101, 0, a);
        wait_cyc(a + 5);
        origin_y = 5'd15; colour = 6'b111111; cells_x = 8'hff; erase = 1'b1;
        wait_cyc(a + 66);
        drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
